cl_rd_ctrl: RTL
===============

Name: cl_rd_ctrl

Overview:
- Read-side sequencer for the pre-AFU cache-line buffer FIFO.
- Waits for a complete AFU frame (ff_rd_ready), latches the frame length sb_len (in STs), and converts it to a CL count.
- Issues ff_rdreq for exactly that many CLs and streams them to the AFU on a valid/ready source port with sop/eop.
- Pulses ff_rd_finish once the last CL is accepted downstream.

Parameters:
- CL, 512, cache-line data width in bits.
- W_LEN, 16, width of sb_len (maximum STs per AFU frame).
- ST_PER_CL, 31, STs carried per CL payload (496/16).
- W_CLCNT, 12, width of the internal CL counter; must hold ceil((2^W_LEN-1)/ST_PER_CL).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ff_rd_ready  in  1  buffer holds one full frame; level signal.
- sb_len  in  W_LEN  frame length in STs; valid while ff_rd_ready=1.
- ff_rdreq  out  1  FIFO read request; normal-mode FIFO, q valid 1 cycle after rdreq.
- ff_q  in  CL  FIFO read data.
- ff_rd_finish  out  1  one-cycle pulse: current frame fully read.
- src_valid  out  1  output CL valid.
- src_data  out  CL  output CL.
- src_sop  out  1  first CL of frame; qualified by src_valid.
- src_eop  out  1  last CL of frame; qualified by src_valid.
- src_ready  in  1  AFU accepts when src_valid & src_ready.
- busy  out  1  high from LOAD until FINISH inclusive.

Behaviour:
- Reset (async assert, synchronous use on deassert) forces the state machine to IDLE and clears all counters and the skid buffer. Outputs are 0: ff_rdreq, ff_rd_finish, src_valid, src_sop, src_eop, busy. src_data is don't-care, registered to 0.
- Reset mid-frame abandons the frame. Re-sync of FIFO contents is upstream's job via its sclr.
- States: IDLE, LOAD, READ, DRAIN, FINISH.
- IDLE -> LOAD when ff_rd_ready=1.
- LOAD (1 cycle): latch sb_len.
  - n_cl = ceil(sb_len/ST_PER_CL), computed by iterative subtraction or a constant-divisor circuit.
  - sb_len=0 is treated as n_cl=1 (the header-only CL is still drained).
  - Set rd_left=n_cl and out_left=n_cl. -> READ.
- READ: ff_rdreq=1 when rd_left!=0 and credit is available.
  - credit: (CLs in skid) + (reads in flight) < 2.
  - Each rdreq decrements rd_left.
  - -> DRAIN when rd_left reaches 0.
- Skid buffer: 2-entry register FIFO capturing ff_q on the cycle after each rdreq. It drives src_*.
  - Full throughput: 1 CL/cycle while src_ready=1.
  - With src_ready=0, no rdreq is issued once 2 entries are committed, so no data is lost.
- Output framing: src_sop=1 on the first CL of the frame. src_eop=1 when out_left=1. out_left decrements on each handshake.
- DRAIN -> FINISH on the handshake with src_eop=1.
- FINISH (1 cycle): ff_rd_finish=1; ff_rd_ready is ignored this cycle. -> IDLE.
- Minimum frame-to-frame gap: LOAD + FINISH + IDLE re-sample = 3 cycles.
- src_valid/src_data/src_sop/src_eop stay stable while src_valid=1 and src_ready=0.
- ff_rdreq is never asserted in IDLE, LOAD, DRAIN or FINISH.
- At most n_cl reads per frame; there are no FIFO underflow checks, since ff_rd_ready guarantees a full frame.
- Latency: ff_rd_ready rise -> first src_valid = 4 cycles (IDLE sample, LOAD, rdreq, skid load).

Optional Feature:
- Macro CL_RD_CTRL_STATS_EN.
- When defined, adds the following outputs:
  - frm_cnt [31:0]: frames completed, incremented on ff_rd_finish, wraps.
  - stall_cnt [31:0]: cycles with src_valid=1 & src_ready=0, saturates at all-ones.
  - Both clear on rst_n.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cl_buf_pkg holds the CL, CL_HEAD, CL_PAYLOAD, ST_W=16 and ST_PER_CL constants, plus the state enum (IDLE, LOAD, READ, DRAIN, FINISH).
- One natural sub-module: cl_skid2, the 2-entry valid/ready skid buffer with credit count output.

Test Plan:
- Basic frame: sb_len=62, src_ready=1 -> 2 CLs. sop on CL0, eop on CL1. ff_rd_finish pulses 1 cycle after the CL1 handshake. Exactly 2 rdreq.
- Rounding: sb_len=63 -> 3 CLs. sb_len=31 -> 1 CL with sop=eop=1. sb_len=0 -> 1 CL, sop=eop=1.
- Backpressure: sb_len=310 (10 CLs), src_ready toggles 1/0 per cycle, then held 0 for 20 cycles. Require:
  - no rdreq while 2 credits are committed;
  - data order matches FIFO order;
  - exactly 10 handshakes.
- Back-to-back frames: ff_rd_ready held high across two frames of 3 CLs each. Require:
  - two ff_rd_finish pulses;
  - second sop no earlier than 3 cycles after the first finish;
  - no CL of frame 2 tagged in frame 1.
- Reset mid-frame: assert rst_n=0 after 4 of 10 CLs. Outputs go to 0 immediately. After release, the controller is IDLE and the next frame of 2 CLs completes normally.
- STATS (macro on): 3 frames with 5 forced stall cycles -> frm_cnt=3, stall_cnt=5.

Source files
------------

// File: rtl/cl_buf_pkg.sv
// Shared cache-line buffer constants and read sequencer state encoding.
package cl_buf_pkg;
  localparam int CL         = 512;
  localparam int CL_HEAD    = 16;
  localparam int CL_PAYLOAD = CL - CL_HEAD;
  localparam int ST_W       = 16;
  localparam int ST_PER_CL  = CL_PAYLOAD / ST_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READ,
    DRAIN,
    FINISH
  } rd_state_e;
endpackage

// File: rtl/cl_rd_ctrl_if.sv
// Valid/ready cache-line source port carrying sop/eop framing to the AFU.
interface cl_rd_ctrl_if
  import cl_buf_pkg::*;
#(
  parameter int DW = CL
);
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_sop;
  logic          src_eop;
  logic          src_ready;

  modport master (output src_valid, src_data, src_sop, src_eop, input src_ready);
  modport slave  (input src_valid, src_data, src_sop, src_eop, output src_ready);
endinterface

// File: rtl/cl_skid2.sv
// Two-entry register FIFO that captures FIFO read data the cycle after each request.
// credit_used_o counts entries that will be occupied next cycle (held + in flight - popping).
module cl_skid2
  import cl_buf_pkg::*;
#(
  parameter int DW = CL
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_issue_i,
  input  logic [DW-1:0] rd_dat_i,
  output logic          out_vld_o,
  output logic [DW-1:0] out_dat_o,
  input  logic          out_rdy_i,
  output logic [1:0]    credit_used_o
);
  logic          pend_q;
  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    cnt_q;
  logic          push;
  logic          pop;

  assign push          = pend_q;
  assign out_vld_o     = (cnt_q != 2'd0);
  assign pop           = out_vld_o & out_rdy_i;
  assign out_dat_o     = mem_q[rd_ptr_q];
  // Counting the current pop lets a fresh request overlap a draining entry at full rate.
  assign credit_used_o = cnt_q - {1'b0, pop} + {1'b0, pend_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      pend_q <= rd_issue_i;
      if (push) begin
        mem_q[wr_ptr_q] <= rd_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/cl_rd_ctrl.sv
// Read sequencer: waits for a full frame, reads ceil(sb_len/ST_PER_CL) CLs and streams them with sop/eop.
// Optional frame/stall counters are built when CL_RD_CTRL_STATS_EN is defined.
module cl_rd_ctrl
  import cl_buf_pkg::*;
#(
  parameter int W_LEN   = 16,
  parameter int W_CLCNT = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ff_rd_ready,
  input  logic [W_LEN-1:0] sb_len,
  output logic             ff_rdreq,
  input  logic [CL-1:0]    ff_q,
  output logic             ff_rd_finish,
  cl_rd_ctrl_if.master     src,
  output logic             busy
`ifdef CL_RD_CTRL_STATS_EN
  ,
  output logic [31:0]      frm_cnt,
  output logic [31:0]      stall_cnt
`endif
);
  rd_state_e          state_q, state_d;
  logic [W_CLCNT-1:0] rd_left_q, rd_left_d;
  logic [W_CLCNT-1:0] out_left_q, out_left_d;
  logic               first_q, first_d;
  logic [W_CLCNT-1:0] n_cl;
  logic [W_LEN:0]     len_rnd;
  logic [1:0]         credit_used;
  logic               skid_vld;
  logic               eop_w;
  logic               hs;

  assign len_rnd = {1'b0, sb_len} + (W_LEN+1)'(ST_PER_CL - 1);

  // An empty frame still carries its header CL.
  always_comb begin
    n_cl = W_CLCNT'(len_rnd / (W_LEN+1)'(ST_PER_CL));
    if (sb_len == '0) begin
      n_cl = W_CLCNT'(1);
    end
  end

  cl_skid2 #(.DW(CL)) u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_issue_i   (ff_rdreq),
    .rd_dat_i     (ff_q),
    .out_vld_o    (skid_vld),
    .out_dat_o    (src.src_data),
    .out_rdy_i    (src.src_ready),
    .credit_used_o(credit_used)
  );

  assign eop_w         = skid_vld & (out_left_q == W_CLCNT'(1));
  assign hs            = skid_vld & src.src_ready;
  assign src.src_valid = skid_vld;
  assign src.src_sop   = skid_vld & first_q;
  assign src.src_eop   = eop_w;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    rd_left_d    = rd_left_q;
    out_left_d   = out_left_q;
    first_d      = first_q;
    ff_rdreq     = 1'b0;
    ff_rd_finish = 1'b0;
    if (hs) begin
      out_left_d = out_left_q - W_CLCNT'(1);
      first_d    = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (ff_rd_ready) state_d = LOAD;
      end
      LOAD: begin
        rd_left_d  = n_cl;
        out_left_d = n_cl;
        first_d    = 1'b1;
        state_d    = READ;
      end
      READ: begin
        ff_rdreq = (rd_left_q != '0) && (credit_used < 2'd2);
        if (ff_rdreq) begin
          rd_left_d = rd_left_q - W_CLCNT'(1);
          if (rd_left_q == W_CLCNT'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (hs && eop_w) state_d = FINISH;
      end
      FINISH: begin
        ff_rd_finish = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_left_q  <= '0;
      out_left_q <= '0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_left_q  <= rd_left_d;
      out_left_q <= out_left_d;
      first_q    <= first_d;
    end
  end

`ifdef CL_RD_CTRL_STATS_EN
  logic [31:0] frm_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (ff_rd_finish) frm_cnt_q <= frm_cnt_q + 32'd1;
      if (skid_vld && !src.src_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign frm_cnt   = frm_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule
